// File: rtl/cdb_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_rr_if
//  Description : Request/broadcast bundle between the functional-unit result
//                channels and the Common Data Bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface cdb_arbiter_rr_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 17,
    parameter int TAG_W  = 4,
    parameter int SRC_W  = $clog2(N_CH)
);
    logic [N_CH-1:0]        req_valid;
    logic [N_CH*TAG_W-1:0]  req_tag;
    logic [N_CH*DATA_W-1:0] req_data;
    logic [N_CH-1:0]        req_ready;
    logic                   cdb_enable;
    logic                   flush;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;
    logic [SRC_W-1:0]       cdb_src;
    logic                   err_tag0;

    // Requesters and control side
    modport master (
        output req_valid, req_tag, req_data, cdb_enable, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_tag, req_data, cdb_enable, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_rr
//  Description : Common Data Bus arbiter. Grants at most one result channel
//                per cycle (round-robin or fixed priority) and broadcasts the
//                winner's tag/data/source on a registered bus.
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter_rr #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 17,
    parameter int TAG_W  = 4,
    parameter int MODE   = 0,
    parameter int SRC_W  = $clog2(N_CH)
) (
    input  wire logic       clock,
    input  wire logic       resetn,
    cdb_arbiter_rr_if.slave bus
);

    localparam logic [SRC_W-1:0] c_last_ch = SRC_W'(N_CH - 1);

    // Arbitration state
    logic [SRC_W-1:0]  r_ptr;
    logic              r_run;   // low until the first edge after reset release

    // Broadcast register
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [SRC_W-1:0]  r_cdb_src;
    logic              r_err_tag0;

    // Arbitration results
    logic              w_arb_en;
    int                w_base;
    int                w_idx;
    logic              w_found;
    logic [SRC_W-1:0]  w_win;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [DATA_W-1:0] w_sel_data;
    logic [N_CH-1:0]   w_grant;
    logic [SRC_W-1:0]  w_ptr_nxt;

    // Flush and a disabled bus both suppress grants; r_run keeps grants off
    // while in reset and for the cycle in which reset is released.
    assign w_arb_en = r_run & bus.cdb_enable & ~bus.flush;

    // Fixed priority always searches from channel 0.
    assign w_base = (MODE == 1) ? 0 : int'(r_ptr);

    // Circular search from the base channel; first valid requester wins.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        w_idx      = 0;
        for (int j = 0; j < N_CH; j++) begin
            w_idx = w_base + j;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!w_found && w_arb_en && bus.req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_win      = SRC_W'(w_idx);
                w_sel_tag  = bus.req_tag[w_idx*TAG_W +: TAG_W];
                w_sel_data = bus.req_data[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot grant vector for the winning channel.
    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // Pointer moves just past the winner, wrapping explicitly for
    // non-power-of-two channel counts.
    assign w_ptr_nxt = (w_win == c_last_ch) ? '0 : w_win + 1'b1;

    // Broadcast register, rotation pointer and sticky tag-0 error.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_run       <= 1'b0;
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
            r_err_tag0  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_found) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= w_sel_tag;
                r_cdb_data  <= w_sel_data;
                r_cdb_src   <= w_win;
                r_ptr       <= (MODE == 1) ? '0 : w_ptr_nxt;
                if (w_sel_tag == '0) begin
                    r_err_tag0 <= 1'b1;
                end
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
    assign bus.cdb_src   = r_cdb_src;
    assign bus.err_tag0  = r_err_tag0;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter_rr
//  Description : Scoreboard bench for cdb_arbiter_rr: 4-channel round-robin,
//                3-channel round-robin and 4-channel fixed-priority instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter_rr;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    cdb_arbiter_rr_if #(.N_CH(4), .DATA_W(17), .TAG_W(4)) if0 ();
    cdb_arbiter_rr_if #(.N_CH(3), .DATA_W(17), .TAG_W(4)) if1 ();
    cdb_arbiter_rr_if #(.N_CH(4), .DATA_W(17), .TAG_W(4)) if2 ();

    cdb_arbiter_rr #(.N_CH(4), .DATA_W(17), .TAG_W(4), .MODE(0)) u0 (.clock(clock), .resetn(resetn), .bus(if0));
    cdb_arbiter_rr #(.N_CH(3), .DATA_W(17), .TAG_W(4), .MODE(0)) u1 (.clock(clock), .resetn(resetn), .bus(if1));
    cdb_arbiter_rr #(.N_CH(4), .DATA_W(17), .TAG_W(4), .MODE(1)) u2 (.clock(clock), .resetn(resetn), .bus(if2));

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus tables
    logic [3:0]  v0, v2;
    logic [2:0]  v1;
    logic [3:0]  tg0[4], tg1[3], tg2[4];
    logic [16:0] dt0[4], dt1[3], dt2[4];
    logic        enable, flsh;

    // expected broadcasts {src[3:0], tag[3:0], data[16:0]}
    logic [24:0] q0[$], q1[$], q2[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic drive();
        if0.req_valid  = v0;
        if0.req_tag    = {tg0[3], tg0[2], tg0[1], tg0[0]};
        if0.req_data   = {dt0[3], dt0[2], dt0[1], dt0[0]};
        if1.req_valid  = v1;
        if1.req_tag    = {tg1[2], tg1[1], tg1[0]};
        if1.req_data   = {dt1[2], dt1[1], dt1[0]};
        if2.req_valid  = v2;
        if2.req_tag    = {tg2[3], tg2[2], tg2[1], tg2[0]};
        if2.req_data   = {dt2[3], dt2[2], dt2[1], dt2[0]};
        if0.cdb_enable = enable; if1.cdb_enable = enable; if2.cdb_enable = enable;
        if0.flush      = flsh;   if1.flush      = flsh;   if2.flush      = flsh;
    endtask

    // Apply current tables, check grants mid-cycle, record expected broadcasts.
    task automatic step(input logic [3:0] g0, input logic [2:0] g1, input logic [3:0] g2, input string nm);
        int k;
        drive();
        @(negedge clock);
        check({nm, "/rdy0"}, 32'(if0.req_ready), 32'(g0));
        check({nm, "/rdy1"}, 32'(if1.req_ready), 32'(g1));
        check({nm, "/rdy2"}, 32'(if2.req_ready), 32'(g2));
        if (g0 != 0) begin k = oh2i(g0);         q0.push_back({4'(k), tg0[k], dt0[k]}); end
        if (g1 != 0) begin k = oh2i({1'b0, g1}); q1.push_back({4'(k), tg1[k], dt1[k]}); end
        if (g2 != 0) begin k = oh2i(g2);         q2.push_back({4'(k), tg2[k], dt2[k]}); end
        @(posedge clock);
        #1;
    endtask

    // Monitors: every valid broadcast must match the oldest expected entry.
    always @(negedge clock) begin
        if (if0.cdb_valid === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bcast0: got unexpected tag %0h src %0h expected none", if0.cdb_tag, if0.cdb_src);
            end else begin
                check("bcast0", 32'({if0.cdb_src, if0.cdb_tag, if0.cdb_data}), 32'(q0.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (if1.cdb_valid === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bcast1: got unexpected tag %0h src %0h expected none", if1.cdb_tag, if1.cdb_src);
            end else begin
                check("bcast1", 32'({2'b00, if1.cdb_src, if1.cdb_tag, if1.cdb_data}), 32'(q1.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (if2.cdb_valid === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL bcast2: got unexpected tag %0h src %0h expected none", if2.cdb_tag, if2.cdb_src);
            end else begin
                check("bcast2", 32'({if2.cdb_src, if2.cdb_tag, if2.cdb_data}), 32'(q2.pop_front()));
            end
        end
    end

    initial begin
        v0 = 4'b1111; v1 = 3'b000; v2 = 4'b0000;
        enable = 1'b1; flsh = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tg0[i] = 4'(i + 1);
            dt0[i] = 17'(32'h11 * (i + 1));
            tg2[i] = 4'(i + 8);
            dt2[i] = 17'(32'h200 + i);
        end
        for (int i = 0; i < 3; i++) begin
            tg1[i] = 4'(i + 5);
            dt1[i] = 17'(32'h15 + i);
        end
        drive();

        // 1. reset with all channels requesting
        #1 resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst/rdy0",  32'(if0.req_ready), 32'h0);
            check("rst/valid", 32'(if0.cdb_valid), 32'h0);
            check("rst/tag",   32'(if0.cdb_tag),   32'h0);
            check("rst/data",  32'(if0.cdb_data),  32'h0);
            check("rst/src",   32'(if0.cdb_src),   32'h0);
            check("rst/err",   32'(if0.err_tag0),  32'h0);
        end
        @(posedge clock); #1 resetn = 1'b1;
        step(4'b0000, 3'b000, 4'b0000, "release");
        step(4'b0001, 3'b000, 4'b0000, "first");

        // 2. round-robin rotation, no gaps
        step(4'b0010, 3'b000, 4'b0000, "rr1");
        step(4'b0100, 3'b000, 4'b0000, "rr2");
        step(4'b1000, 3'b000, 4'b0000, "rr3");
        step(4'b0001, 3'b000, 4'b0000, "rr0");
        step(4'b0010, 3'b000, 4'b0000, "rr1b");     // ptr -> 2

        // 3. sparse request and wrap with ptr=2
        v0 = 4'b1010;
        step(4'b1000, 3'b000, 4'b0000, "sparse3");  // ptr -> 0
        step(4'b0010, 3'b000, 4'b0000, "sparse1");
        v0 = 4'b0000;

        // 3b. three-channel wrap 2 -> 0
        v1 = 3'b111;
        step(4'b0000, 3'b001, 4'b0000, "n3_0");
        step(4'b0000, 3'b010, 4'b0000, "n3_1");
        step(4'b0000, 3'b100, 4'b0000, "n3_2");
        step(4'b0000, 3'b001, 4'b0000, "n3_wrap");
        step(4'b0000, 3'b010, 4'b0000, "n3_1b");
        v1 = 3'b000;

        // 4. fixed priority
        v2 = 4'b0100;
        step(4'b0000, 3'b000, 4'b0100, "fp2");
        v2 = 4'b0101;
        step(4'b0000, 3'b000, 4'b0001, "fp0a");
        step(4'b0000, 3'b000, 4'b0001, "fp0b");
        step(4'b0000, 3'b000, 4'b0001, "fp0c");
        v2 = 4'b0100;
        step(4'b0000, 3'b000, 4'b0100, "fp2b");
        v2 = 4'b0000;

        // 5. flush and enable
        v0 = 4'b0001;
        step(4'b0001, 3'b000, 4'b0000, "pre_flush");
        v0 = 4'b0010; tg0[1] = 4'h6; dt0[1] = 17'h1ABCD; flsh = 1'b1;
        step(4'b0000, 3'b000, 4'b0000, "flush");
        check("flush/valid", 32'(if0.cdb_valid), 32'h0);
        flsh = 1'b0; enable = 1'b0;
        step(4'b0000, 3'b000, 4'b0000, "dis_a");
        check("dis/valid", 32'(if0.cdb_valid), 32'h0);
        step(4'b0000, 3'b000, 4'b0000, "dis_b");
        enable = 1'b1;
        step(4'b0010, 3'b000, 4'b0000, "after_en");
        v0 = 4'b0000;

        // 6. tag 0 and mid-cycle reset
        check("err/before", 32'(if0.err_tag0), 32'h0);
        v0 = 4'b0100; tg0[2] = 4'h0; dt0[2] = 17'h0F0F0;
        step(4'b0100, 3'b000, 4'b0000, "tag0");
        check("err/set", 32'(if0.err_tag0), 32'h1);
        v0 = 4'b0000;
        step(4'b0000, 3'b000, 4'b0000, "idle_a");
        check("err/sticky", 32'(if0.err_tag0), 32'h1);
        v0 = 4'b0100; tg0[2] = 4'h3; dt0[2] = 17'h12345;
        drive();
        @(negedge clock);
        check("lost/rdy0", 32'(if0.req_ready), 32'h4);
        @(posedge clock); #1;
        check("lost/valid_pre", 32'(if0.cdb_valid), 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("mrst/valid", 32'(if0.cdb_valid), 32'h0);
        check("mrst/err",   32'(if0.err_tag0),  32'h0);
        check("mrst/rdy0",  32'(if0.req_ready), 32'h0);
        @(posedge clock); #1 resetn = 1'b1;
        step(4'b0000, 3'b000, 4'b0000, "mrst_release");
        step(4'b0100, 3'b000, 4'b0000, "pending");
        v0 = 4'b0000;
        step(4'b0000, 3'b000, 4'b0000, "tail_a");
        step(4'b0000, 3'b000, 4'b0000, "tail_b");

        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q2_drained", 32'(q2.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter_rr.md
# cdb_arbiter_rr

Parametrised Common Data Bus arbiter for the Tomasulo core. It collects completed results from N functional-unit channels (add/sub, mul/div, load, ...) over valid/ready handshakes and grants at most one per cycle, round-robin or fixed priority. It broadcasts the winner's tag and data on a registered CDB to the reservation stations and the register bank. It replaces the two-input, switch-selected CDB mux with fair arbitration, back-pressure, flush and source identification.

## Interface
- N_CH, 4, number of requesting channels (2..16)
- DATA_W, 17, result width
- TAG_W, 4, reservation-station tag width; tag 0 is reserved ("no producer")
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- SRC_W, $clog2(N_CH), width of cdb_src

- clock  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  N_CH  channel i has a result pending
- req_tag  in  N_CH*TAG_W  channel i tag in bits [i*TAG_W +: TAG_W]
- req_data  in  N_CH*DATA_W  channel i result in bits [i*DATA_W +: DATA_W]
- req_ready  out  N_CH  one-hot (or zero) grant, combinational
- cdb_enable  in  1  0 = no grants this cycle
- flush  in  1  squash: no grant this cycle, clear the broadcast next edge
- cdb_valid  out  1  broadcast valid, registered
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast result
- cdb_src  out  SRC_W  index of the winning channel
- err_tag0  out  1  sticky: a tag-0 request was accepted

## Operation
- A transfer on channel i occurs on a rising edge where req_valid[i] & req_ready[i] are both high.
- A requester holds valid, tag and data stable until its transfer. Dropping valid before the transfer is allowed: the request is withdrawn and never broadcast.
- Grant is computed combinationally. When cdb_enable=1, flush=0 and any req_valid is set, exactly one req_ready bit is high. Otherwise req_ready=0.
- Round-robin (MODE=0):
  - A pointer ptr (SRC_W bits) marks the highest-priority channel. The search order is ptr, ptr+1, ..., wrapping mod N_CH.
  - After a transfer from channel k, ptr becomes (k+1) mod N_CH. The wrap applies for non-power-of-2 N_CH: from N_CH-1 it goes to 0.
  - With no transfer, ptr is unchanged.
- Fixed priority (MODE=1): the lowest valid index wins, and ptr stays at 0.
- Broadcast register:
  - On a transfer, the next edge loads cdb_valid=1 and the winner's cdb_tag, cdb_data and cdb_src.
  - With no transfer, cdb_valid=0 while tag, data and src hold their last values.
- Flush has priority over everything. The edge with flush=1 loads cdb_valid=0, makes no transfer and leaves ptr unchanged.
- A tag-0 request is granted and broadcast like any other, and sets err_tag0. Only reset clears err_tag0.
- No arithmetic is performed. Data passes bit-exact with no width change.

## Timing
- Reset (async assert, any time): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag0=0, ptr=0.
  - req_ready is 0 while resetn=0.
  - An in-flight broadcast is lost. Any request not yet transferred stays pending and is granted after release.
- Deassertion is taken synchronously at the next rising edge, with no grants until then.
- Latency: a transfer at edge T produces cdb_valid=1 during cycle T..T+1, exactly one cycle wide per transfer.
- Throughput: one transfer per cycle. Back-to-back transfers give continuous cdb_valid.
- Fairness: in MODE=0, a continuously valid channel is granted within N_CH transfers.
- A requester whose valid stays high after its transfer is treated as a new result.
- cdb_enable=0 blocks grants only. The register still clears cdb_valid at the next edge.

## Test plan
1. Reset and idle: hold resetn=0 for 3 cycles with all req_valid=1. Required: req_ready=0000 and all outputs 0 during reset. After release, the first grant is ch0, and on the next cycle cdb_valid=1 with cdb_src=0.
2. Round-robin rotation (N_CH=4, MODE=0): all four channels valid continuously with tags 1..4 and data 0x00011..0x00044. Required: grant order 0,1,2,3,0,... and cdb_tag sequence 1,2,3,4,1 with no gap cycles.
3. Sparse and wrap: ch3 and ch1 valid with ptr=2. Required: ch3 wins, ptr goes to 0, then ch1 wins. Also run N_CH=3 and check the wrap from 2 to 0.
4. Fixed priority (MODE=1): ch2 valid continuously, then ch0 asserted. Required: ch0 wins every cycle while valid and ch2 waits.
5. Flush and enable: flush=1 while ch1 is valid, then cdb_enable=0 for 2 cycles. Required: req_ready=0 and cdb_valid=0 next cycle; ch1 is granted on the first cycle both are deasserted, with data 0x1ABCD delivered bit-exact.
6. Tag 0 and mid-operation reset: ch2 sends tag 0. Required: broadcast with cdb_tag=0 and err_tag0=1 sticky. Then assert resetn=0 mid-cycle while cdb_valid=1. Required: cdb_valid=0 immediately and err_tag0=0.
